// File: rtl/etpu_wb_pkg.sv
// Shared definitions for the etpu Wishbone initiator.
// Contents: FSM state encoding, default bus widths, and the TPU register
// offsets that bring-up and test sequences address.
package etpu_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wbm_state_e;

  localparam int ETPU_ADDR_W = 32;
  localparam int ETPU_DATA_W = 32;

  // TPU slave register map (byte offsets from the user-area base)
  localparam logic [31:0] ETPU_BASE       = 32'h3000_0000;
  localparam logic [31:0] ETPU_REG_CTRL   = 32'h0000_0000;
  localparam logic [31:0] ETPU_REG_STATUS = 32'h0000_0004;
  localparam logic [31:0] ETPU_REG_ADDR   = 32'h0000_0008;
  localparam logic [31:0] ETPU_REG_WDATA  = 32'h0000_000C;
  localparam logic [31:0] ETPU_REG_RDATA  = 32'h0000_0010;

endpackage

// File: rtl/etpu_wb_master.sv
// etpu_wb_master: Wishbone classic initiator driven by a command/response
// stream. Each accepted command becomes exactly one single-beat Wishbone
// read or write; the result (read data, or 0 for writes) and an error flag
// come back on the response stream.
//
// Ports:
//   wb_clk_i, wb_rst_ni          clock, async active-low reset
//   cmd_valid_i / cmd_ready_o    command handshake
//   cmd_we_i, cmd_adr_i,
//   cmd_dat_i, cmd_sel_i         command fields
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_dat_o, rsp_err_o         read data (0 for writes), timeout flag
//   wbm_*                        Wishbone initiator port
//   busy_o                       FSM not in IDLE
//   txn_count_o                  completed transactions, wraps at 16 bits
//
// Build option: define ETPU_WBM_TIMEOUT_EN to abort a bus cycle that sees no
// ack after TIMEOUT_CYCLES wait cycles. Without it BUS waits indefinitely
// and rsp_err_o is tied low.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a command; Wishbone cycle inactive
// BUS   | cyc/stb asserted with latched fields, waiting for ack
// RESP  | response held on rsp_* until the consumer takes it
module etpu_wb_master
  import etpu_wb_pkg::*;
#(
  parameter int ADDR_W         = ETPU_ADDR_W,
  parameter int DATA_W         = ETPU_DATA_W,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SEL_W         = DATA_W / 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,

  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_adr_i,
  input  logic [DATA_W-1:0] cmd_dat_i,
  input  logic [SEL_W-1:0]  cmd_sel_i,

  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_dat_o,
  output logic              rsp_err_o,

  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  output logic [SEL_W-1:0]  wbm_sel_o,
  input  logic              wbm_ack_i,
  input  logic [DATA_W-1:0] wbm_dat_i,

  output logic              busy_o,
  output logic [15:0]       txn_count_o
);

  wbm_state_e state;

`ifdef ETPU_WBM_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WAIT_LIMIT = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] wait_cnt;
  logic          err_q;

  assign rsp_err_o = err_q;
`else
  logic unused_timeout;

  assign rsp_err_o      = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
      busy_o      <= 1'b0;
      txn_count_o <= '0;
`ifdef ETPU_WBM_TIMEOUT_EN
      wait_cnt    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            wbm_we_o    <= cmd_we_i;
            wbm_adr_o   <= cmd_adr_i;
            wbm_dat_o   <= cmd_dat_i;
            wbm_sel_o   <= cmd_sel_i;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state       <= BUS;
`ifdef ETPU_WBM_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
          end
        end

        BUS: begin
          // cyc/stb drop on the ack edge itself, so a slave with a
          // combinational ack never sees a second strobe.
          if (wbm_ack_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_valid_o <= 1'b1;
            txn_count_o <= txn_count_o + 16'd1;
            state       <= RESP;
`ifdef ETPU_WBM_TIMEOUT_EN
            err_q       <= 1'b0;
          end else if (wait_cnt == WAIT_LIMIT) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_valid_o <= 1'b1;
            err_q       <= 1'b1;
            txn_count_o <= txn_count_o + 16'd1;
            state       <= RESP;
          end else begin
            wait_cnt    <= wait_cnt + 1'b1;
`endif
          end
        end

        RESP: begin
          // cmd_ready rises only after the handshake edge, so no command
          // can be accepted in the same cycle the response is consumed.
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          wbm_cyc_o   <= 1'b0;
          wbm_stb_o   <= 1'b0;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
